// File: rtl/ama_riscv_pkg.sv
// Shared encodings, control payload and FSM state type for the RV32I ID-stage control decoder.
package ama_riscv_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [4:0] OPC5_LOAD   = 5'b00000;
  localparam logic [4:0] OPC5_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC5_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC5_STORE  = 5'b01000;
  localparam logic [4:0] OPC5_OP     = 5'b01100;
  localparam logic [4:0] OPC5_LUI    = 5'b01101;
  localparam logic [4:0] OPC5_BRANCH = 5'b11000;
  localparam logic [4:0] OPC5_JALR   = 5'b11001;
  localparam logic [4:0] OPC5_JAL    = 5'b11011;

  localparam logic [1:0] PC_SEL_INC4       = 2'd0;
  localparam logic [1:0] PC_SEL_ALU        = 2'd1;
  localparam logic [1:0] PC_SEL_START_ADDR = 2'd2;

  localparam logic ALU_A_SEL_RS1 = 1'b0;
  localparam logic ALU_A_SEL_PC  = 1'b1;
  localparam logic ALU_B_SEL_RS2 = 1'b0;
  localparam logic ALU_B_SEL_IMM = 1'b1;

  localparam logic [2:0] IG_DIS = 3'd0;
  localparam logic [2:0] IG_I   = 3'd1;
  localparam logic [2:0] IG_S   = 3'd2;
  localparam logic [2:0] IG_B   = 3'd3;
  localparam logic [2:0] IG_J   = 3'd4;
  localparam logic [2:0] IG_U   = 3'd5;

  localparam logic [1:0] WB_SEL_DMEM = 2'd0;
  localparam logic [1:0] WB_SEL_ALU  = 2'd1;
  localparam logic [1:0] WB_SEL_INC4 = 2'd2;

  localparam logic [3:0] ALU_OP_ADD    = 4'b0000;
  localparam logic [3:0] ALU_OP_PASS_B = 4'b1111;

  typedef enum logic [2:0] {
    ST_START,
    ST_RUN,
    ST_RESOLVE,
    ST_FLUSH,
    ST_TRAP
  } state_t;

  // Every registered control except alu_op_sel, whose width is a top-level parameter.
  typedef struct packed {
    logic       stall_if;
    logic       clear_if;
    logic       clear_id;
    logic [1:0] pc_sel;
    logic       pc_we;
    logic       branch_inst;
    logic       jump_inst;
    logic       load_inst;
    logic       store_inst;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [2:0] ig_sel;
    logic       bc_uns;
    logic       dmem_en;
    logic       load_sm_en;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       illegal_inst;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t ctrl_start();
    ctrl_t c;
    c        = CTRL_BUBBLE;
    c.pc_sel = PC_SEL_START_ADDR;
    c.pc_we  = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_trap();
    ctrl_t c;
    c              = CTRL_BUBBLE;
    c.stall_if     = 1'b1;
    c.illegal_inst = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/ama_riscv_branch_resolve.sv
// Decides whether the branch/jump held in RESOLVE redirects the PC.
module ama_riscv_branch_resolve (
  input  logic [2:0] funct3,
  input  logic       a_eq_b,
  input  logic       a_lt_b,
  input  logic       jump,
  output logic       taken_c
);

  always_comb begin
    taken_c = 1'b0;
    if (jump) begin
      taken_c = 1'b1;
    end else begin
      case (funct3)
        3'b000:         taken_c = a_eq_b;
        3'b001:         taken_c = ~a_eq_b;
        3'b100, 3'b110: taken_c = a_lt_b;
        3'b101, 3'b111: taken_c = ~a_lt_b;
        default:        taken_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ama_riscv_ctrl_decoder.sv
// RV32I ID-stage control decoder: registered datapath selects plus start/resolve/flush/trap FSM.
module ama_riscv_ctrl_decoder
  import ama_riscv_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned ALU_OP_W     = 4,
  parameter int unsigned EN_TRAP      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         inst_id,
  input  logic                inst_valid,
  input  logic                bc_a_eq_b,
  input  logic                bc_a_lt_b,
  output logic                stall_if,
  output logic                clear_if,
  output logic                clear_id,
  output logic [1:0]          pc_sel,
  output logic                pc_we,
  output logic                branch_inst,
  output logic                jump_inst,
  output logic                load_inst,
  output logic                store_inst,
  output logic [ALU_OP_W-1:0] alu_op_sel,
  output logic                alu_a_sel,
  output logic                alu_b_sel,
  output logic [2:0]          ig_sel,
  output logic                bc_uns,
  output logic                dmem_en,
  output logic                load_sm_en,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                illegal_inst
);

  state_t              state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                jump_q, jump_d;

  ctrl_t               dec;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_illegal;
  logic                dec_cf;
  logic                dec_jump;
  logic                taken_c;
  logic                run_decode;

  logic [4:0] opc5;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_bits;

  assign opc5        = inst_id[6:2];
  assign f3          = inst_id[14:12];
  assign f7b5        = inst_id[30];
  assign unused_bits = ^{inst_id[31], inst_id[29:15], inst_id[11:7]};

  ama_riscv_branch_resolve u_branch_resolve (
    .funct3  (f3_q),
    .a_eq_b  (bc_a_eq_b),
    .a_lt_b  (bc_a_lt_b),
    .jump    (jump_q),
    .taken_c (taken_c)
  );

  // Pure instruction decode, used wherever the FSM accepts a new instruction.
  always_comb begin
    dec         = CTRL_BUBBLE;
    dec.pc_we   = 1'b1;
    dec_alu_op  = ALU_OP_W'(ALU_OP_ADD);
    dec_illegal = 1'b0;
    dec_cf      = 1'b0;
    dec_jump    = 1'b0;
    if (inst_valid) begin
      if (inst_id[1:0] != 2'b11) begin
        dec_illegal = 1'b1;
      end else begin
        case (opc5)
          OPC5_OP: begin
            dec_alu_op = ALU_OP_W'({f7b5, f3});
            dec.wb_sel = WB_SEL_ALU;
            dec.reg_we = 1'b1;
          end
          OPC5_OP_IMM: begin
            dec_alu_op    = ALU_OP_W'({(f3 == 3'b101) & f7b5, f3});
            dec.ig_sel    = IG_I;
            dec.alu_b_sel = ALU_B_SEL_IMM;
            dec.wb_sel    = WB_SEL_ALU;
            dec.reg_we    = 1'b1;
          end
          OPC5_LOAD: begin
            dec.ig_sel     = IG_I;
            dec.alu_b_sel  = ALU_B_SEL_IMM;
            dec.dmem_en    = 1'b1;
            dec.load_sm_en = 1'b1;
            dec.load_inst  = 1'b1;
            dec.wb_sel     = WB_SEL_DMEM;
            dec.reg_we     = 1'b1;
          end
          OPC5_STORE: begin
            dec.ig_sel     = IG_S;
            dec.alu_b_sel  = ALU_B_SEL_IMM;
            dec.dmem_en    = 1'b1;
            dec.store_inst = 1'b1;
          end
          OPC5_LUI: begin
            dec_alu_op    = ALU_OP_W'(ALU_OP_PASS_B);
            dec.ig_sel    = IG_U;
            dec.alu_b_sel = ALU_B_SEL_IMM;
            dec.wb_sel    = WB_SEL_ALU;
            dec.reg_we    = 1'b1;
          end
          OPC5_AUIPC: begin
            dec.alu_a_sel = ALU_A_SEL_PC;
            dec.alu_b_sel = ALU_B_SEL_IMM;
            dec.ig_sel    = IG_U;
            dec.wb_sel    = WB_SEL_ALU;
            dec.reg_we    = 1'b1;
          end
          OPC5_JAL: begin
            dec.alu_a_sel = ALU_A_SEL_PC;
            dec.alu_b_sel = ALU_B_SEL_IMM;
            dec.ig_sel    = IG_J;
            dec.wb_sel    = WB_SEL_INC4;
            dec.reg_we    = 1'b1;
            dec.jump_inst = 1'b1;
            dec_cf        = 1'b1;
            dec_jump      = 1'b1;
          end
          OPC5_JALR: begin
            dec.alu_b_sel = ALU_B_SEL_IMM;
            dec.ig_sel    = IG_I;
            dec.wb_sel    = WB_SEL_INC4;
            dec.reg_we    = 1'b1;
            dec.jump_inst = 1'b1;
            dec_cf        = 1'b1;
            dec_jump      = 1'b1;
          end
          OPC5_BRANCH: begin
            if (f3[2:1] == 2'b01) begin
              dec_illegal = 1'b1;
            end else begin
              dec.alu_a_sel   = ALU_A_SEL_PC;
              dec.alu_b_sel   = ALU_B_SEL_IMM;
              dec.ig_sel      = IG_B;
              dec.bc_uns      = f3[1];
              dec.branch_inst = 1'b1;
              dec_cf          = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
    end
    if (dec_illegal) begin
      dec        = CTRL_BUBBLE;
      dec.pc_we  = 1'b1;
      dec_alu_op = ALU_OP_W'(ALU_OP_ADD);
      dec_cf     = 1'b0;
      dec_jump   = 1'b0;
    end
    // Hold IF until the target is known; the compare flags arrive from EX next cycle.
    if (dec_cf) begin
      dec.pc_we    = 1'b0;
      dec.stall_if = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = CTRL_BUBBLE;
    alu_op_d   = ALU_OP_W'(ALU_OP_ADD);
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    jump_d     = jump_q;
    run_decode = 1'b0;
    case (state_q)
      ST_START: begin
        ctrl_d  = ctrl_start();
        state_d = ST_RUN;
      end
      ST_RUN: run_decode = 1'b1;
      ST_RESOLVE: begin
        if (taken_c) begin
          ctrl_d.pc_sel   = PC_SEL_ALU;
          ctrl_d.pc_we    = 1'b1;
          ctrl_d.clear_if = 1'b1;
          ctrl_d.clear_id = 1'b1;
          cnt_d           = CNT_W'(FLUSH_CYCLES);
          state_d         = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
        end else begin
          run_decode = 1'b1;
        end
      end
      ST_FLUSH: begin
        ctrl_d.pc_we = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_TRAP: ctrl_d = ctrl_trap();
      default: state_d = ST_START;
    endcase
    if (run_decode) begin
      if (dec_illegal && (EN_TRAP != 0)) begin
        ctrl_d  = ctrl_trap();
        state_d = ST_TRAP;
      end else begin
        ctrl_d   = dec;
        alu_op_d = dec_alu_op;
        state_d  = dec_cf ? ST_RESOLVE : ST_RUN;
        if (dec_cf) begin
          f3_d   = f3;
          jump_d = dec_jump;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_START;
      ctrl_q   <= ctrl_start();
      alu_op_q <= ALU_OP_W'(ALU_OP_ADD);
      cnt_q    <= '0;
      f3_q     <= '0;
      jump_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      alu_op_q <= alu_op_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      jump_q   <= jump_d;
    end
  end

  assign stall_if     = ctrl_q.stall_if;
  assign clear_if     = ctrl_q.clear_if;
  assign clear_id     = ctrl_q.clear_id;
  assign pc_sel       = ctrl_q.pc_sel;
  assign pc_we        = ctrl_q.pc_we;
  assign branch_inst  = ctrl_q.branch_inst;
  assign jump_inst    = ctrl_q.jump_inst;
  assign load_inst    = ctrl_q.load_inst;
  assign store_inst   = ctrl_q.store_inst;
  assign alu_op_sel   = alu_op_q;
  assign alu_a_sel    = ctrl_q.alu_a_sel;
  assign alu_b_sel    = ctrl_q.alu_b_sel;
  assign ig_sel       = ctrl_q.ig_sel;
  assign bc_uns       = ctrl_q.bc_uns;
  assign dmem_en      = ctrl_q.dmem_en;
  assign load_sm_en   = ctrl_q.load_sm_en;
  assign reg_we       = ctrl_q.reg_we;
  assign wb_sel       = ctrl_q.wb_sel;
  assign illegal_inst = ctrl_q.illegal_inst;

endmodule

// File: tb/tb_ama_riscv_ctrl_decoder.sv
// Self-checking bench: directed scenarios plus random legal instruction streams against a behavioural model.
module tb_ama_riscv_ctrl_decoder;

  localparam int unsigned FLUSH = 2;

  typedef struct packed {
    logic       stall_if;
    logic       clear_if;
    logic       clear_id;
    logic [1:0] pc_sel;
    logic       pc_we;
    logic       branch_inst;
    logic       jump_inst;
    logic       load_inst;
    logic       store_inst;
    logic [3:0] alu_op;
    logic       alu_a;
    logic       alu_b;
    logic [2:0] ig;
    logic       bc_uns;
    logic       dmem_en;
    logic       load_sm_en;
    logic       reg_we;
    logic [1:0] wb;
    logic       illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_id = '0;
  logic        inst_valid = 1'b0;
  logic        bc_a_eq_b = 1'b0;
  logic        bc_a_lt_b = 1'b0;

  logic       stall_if, clear_if, clear_id, pc_we;
  logic [1:0] pc_sel, wb_sel;
  logic       branch_inst, jump_inst, load_inst, store_inst;
  logic [3:0] alu_op_sel;
  logic       alu_a_sel, alu_b_sel, bc_uns, dmem_en, load_sm_en, reg_we, illegal_inst;
  logic [2:0] ig_sel;

  int errors = 0;
  int checks = 0;

  // Model bookkeeping
  bit         started;
  bit         trapped;
  bit         pending;
  bit         pend_jump;
  logic [2:0] pend_f3;
  int         flush_left;

  exp_t obs;
  assign obs = {stall_if, clear_if, clear_id, pc_sel, pc_we, branch_inst, jump_inst,
                load_inst, store_inst, alu_op_sel, alu_a_sel, alu_b_sel, ig_sel,
                bc_uns, dmem_en, load_sm_en, reg_we, wb_sel, illegal_inst};

  ama_riscv_ctrl_decoder #(.FLUSH_CYCLES(FLUSH), .ALU_OP_W(4), .EN_TRAP(1)) dut (
    .clk(clk), .rst(rst), .inst_id(inst_id), .inst_valid(inst_valid),
    .bc_a_eq_b(bc_a_eq_b), .bc_a_lt_b(bc_a_lt_b),
    .stall_if(stall_if), .clear_if(clear_if), .clear_id(clear_id),
    .pc_sel(pc_sel), .pc_we(pc_we),
    .branch_inst(branch_inst), .jump_inst(jump_inst), .load_inst(load_inst),
    .store_inst(store_inst), .alu_op_sel(alu_op_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .ig_sel(ig_sel), .bc_uns(bc_uns), .dmem_en(dmem_en),
    .load_sm_en(load_sm_en), .reg_we(reg_we), .wb_sel(wb_sel),
    .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_vals();
    exp_t e = '0;
    e.pc_sel = 2'd2;
    e.pc_we  = 1'b1;
    return e;
  endfunction

  function automatic exp_t trap_vals();
    exp_t e = '0;
    e.stall_if = 1'b1;
    e.illegal  = 1'b1;
    return e;
  endfunction

  // Reference decode of one valid instruction, keyed on the full 7-bit opcode.
  function automatic exp_t ref_decode(input logic [31:0] i, output bit ill, output bit cf);
    exp_t       e = '0;
    logic [2:0] f = i[14:12];
    ill = 1'b0;
    cf  = 1'b0;
    e.pc_we = 1'b1;
    case (i[6:0])
      7'b0110011: begin e.alu_op = {i[30], f}; e.wb = 2'd1; e.reg_we = 1; end
      7'b0010011: begin
        e.alu_op = {(f == 3'd5) ? i[30] : 1'b0, f};
        e.ig = 3'd1; e.alu_b = 1; e.wb = 2'd1; e.reg_we = 1;
      end
      7'b0000011: begin
        e.ig = 3'd1; e.alu_b = 1; e.dmem_en = 1; e.load_sm_en = 1; e.load_inst = 1;
        e.wb = 2'd0; e.reg_we = 1;
      end
      7'b0100011: begin e.ig = 3'd2; e.alu_b = 1; e.dmem_en = 1; e.store_inst = 1; end
      7'b0110111: begin e.ig = 3'd5; e.alu_b = 1; e.alu_op = 4'hF; e.wb = 2'd1; e.reg_we = 1; end
      7'b0010111: begin e.ig = 3'd5; e.alu_a = 1; e.alu_b = 1; e.wb = 2'd1; e.reg_we = 1; end
      7'b1101111: begin
        e.ig = 3'd4; e.alu_a = 1; e.alu_b = 1; e.wb = 2'd2; e.reg_we = 1; e.jump_inst = 1; cf = 1;
      end
      7'b1100111: begin
        e.ig = 3'd1; e.alu_b = 1; e.wb = 2'd2; e.reg_we = 1; e.jump_inst = 1; cf = 1;
      end
      7'b1100011: begin
        if (f == 3'd2 || f == 3'd3) ill = 1'b1;
        else begin
          e.ig = 3'd3; e.alu_a = 1; e.alu_b = 1; e.bc_uns = f[1]; e.branch_inst = 1; cf = 1;
        end
      end
      default: ill = 1'b1;
    endcase
    if (cf) begin
      e.pc_we    = 1'b0;
      e.stall_if = 1'b1;
    end
    return e;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f, input bit jmp, input bit eq, input bit lt);
    if (jmp) return 1'b1;
    case (f)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  // Expected outputs after the coming clock edge, given the inputs now applied.
  task automatic model_step(output exp_t e);
    bit   ill, cf;
    exp_t d;
    e = '0;
    if (!started) begin
      e = reset_vals();
      started = 1'b1;
    end else if (trapped) begin
      e = trap_vals();
    end else if (flush_left > 0) begin
      e.pc_we = 1'b1;
      flush_left--;
    end else if (pending && ref_taken(pend_f3, pend_jump, bc_a_eq_b, bc_a_lt_b)) begin
      pending = 1'b0;
      e.pc_sel = 2'd1; e.pc_we = 1'b1; e.clear_if = 1'b1; e.clear_id = 1'b1;
      flush_left = FLUSH;
    end else begin
      pending = 1'b0;
      if (!inst_valid) begin
        e.pc_we = 1'b1;
      end else begin
        d = ref_decode(inst_id, ill, cf);
        if (ill) begin
          trapped = 1'b1;
          e = trap_vals();
        end else begin
          e = d;
          if (cf) begin
            pending   = 1'b1;
            pend_f3   = inst_id[14:12];
            pend_jump = (inst_id[6:0] == 7'b1101111) || (inst_id[6:0] == 7'b1100111);
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input exp_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_step(e);
    @(posedge clk);
    #1;
    chk(tag, e);
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic eq, input logic lt);
    inst_id = i; inst_valid = v; bc_a_eq_b = eq; bc_a_lt_b = lt;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge, then released on a negedge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    started = 0; trapped = 0; pending = 0; flush_left = 0;
    #1 chk(tag, reset_vals());
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  opcs [9];
    logic [2:0]  bf3  [6];
    logic [31:0] i;
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
             7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
    bf3  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    i = $urandom;
    i[6:0] = opcs[$urandom_range(0, 8)];
    if (i[6:0] == 7'b1100011) i[14:12] = bf3[$urandom_range(0, 5)];
    return i;
  endfunction

  initial begin
    started = 0; trapped = 0; pending = 0; flush_left = 0;
    pend_f3 = '0; pend_jump = 0;

    // Power-on reset and start-address load
    do_reset("reset_initial");
    step("start_edge");
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    step("run_idle_bubble");

    drive(32'h003100B3, 1'b1, 1'b0, 1'b0);
    step("add");
    drive(32'h403100B3, 1'b1, 1'b0, 1'b0);
    step("sub");

    // beq taken, then two flush bubbles that ignore inst_id
    drive(32'h00000063, 1'b1, 1'b0, 1'b0);
    step("beq_decode");
    drive(32'h003100B3, 1'b1, 1'b1, 1'b0);
    step("beq_redirect");
    step("flush_1");
    step("flush_2");
    step("after_flush_add");

    // bltu not taken, resolve edge decodes the next instruction
    drive(32'h00006063, 1'b1, 1'b0, 1'b0);
    step("bltu_decode");
    drive(32'h403100B3, 1'b1, 1'b0, 1'b0);
    step("bltu_not_taken_sub");

    // Not-taken resolve with no valid instruction
    drive(32'h00001063, 1'b1, 1'b0, 1'b0);
    step("bne_decode");
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    step("bne_not_taken_bubble");

    // Random legal stream
    for (int n = 0; n < 400; n++) begin
      drive(rand_inst(), ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom));
      step("random");
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) step("drain");

    // Reset during FLUSH
    drive(32'h0000006F, 1'b1, 1'b0, 1'b0);
    step("jal_decode");
    step("jal_redirect");
    step("jal_flush_1");
    do_reset("reset_in_flush");
    step("start_after_flush_reset");
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    step("run_after_flush_reset");

    // Illegal instruction traps until reset
    drive(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    step("trap_entry");
    drive(32'h003100B3, 1'b1, 1'b0, 1'b0);
    step("trap_hold_1");
    step("trap_hold_2");
    do_reset("reset_in_trap");
    step("start_after_trap");
    step("add_after_trap");

    // Unlisted opcode (FENCE) and reserved branch funct3 also trap
    drive(32'h0000000F, 1'b1, 1'b0, 1'b0);
    step("fence_trap");
    do_reset("reset_after_fence");
    step("start_after_fence");
    drive(32'h00002063, 1'b1, 1'b0, 1'b0);
    step("branch_f3_010_trap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ama_riscv_ctrl_decoder.md
# ama_riscv_ctrl_decoder

Parametrised successor to the single-format ID-stage decoder: decodes all RV32I base opcodes into registered datapath controls and adds a control FSM for reset start-address load, branch/jump resolution, post-redirect flush and illegal-instruction trapping. Sits in ID, drives the EX-stage mux/ALU/immediate-generator selects and the IF/ID pipeline stall/clear lines; consumes branch-compare flags from EX.

## Interface
- FLUSH_CYCLES, 1 — extra bubble cycles after a redirect (0..7)
- ALU_OP_W, 4 — width of alu_op_sel
- EN_TRAP, 1 — 1: illegal instruction halts in TRAP; 0: treated as bubble

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- inst_id  in  32  instruction in ID
- inst_valid  in  1  inst_id holds a real instruction
- bc_a_eq_b, bc_a_lt_b  in  1  EX compare flags for the currently registered branch
- stall_if, clear_if, clear_id  out  1  pipeline control
- pc_sel  out  2  INC4=0, ALU=1, START_ADDR=2
- pc_we  out  1  PC write enable
- branch_inst, jump_inst, load_inst, store_inst  out  1  class flags
- alu_op_sel  out  ALU_OP_W  {funct7[5],funct3}; ADD=0000, PASS_B=1111
- alu_a_sel  out  1  RS1=0, PC=1
- alu_b_sel  out  1  RS2=0, IMM=1
- ig_sel  out  3  DIS=0, I=1, S=2, B=3, J=4, U=5
- bc_uns  out  1  unsigned compare
- dmem_en, load_sm_en, reg_we  out  1  enables
- wb_sel  out  2  DMEM=0, ALU=1, INC4=2
- illegal_inst  out  1  sticky trap flag

## Operation
- States: START, RUN, RESOLVE, FLUSH, TRAP. All outputs registered from state + combinational decode.
- Bubble = all enables/class flags 0, alu_op ADD, selects 0, ig DIS.
- START: pc_sel=START_ADDR, pc_we=1, bubble; -> RUN next edge.
- RUN, inst_valid=0: bubble, pc_sel=INC4, pc_we=1.
- RUN decode: R: alu_op {f7[5],f3}, B=RS2, wb ALU, reg_we. I-ALU: alu_op {f3==101?f7[5]:0,f3}, ig I, B=IMM. LOAD: ig I, ADD, dmem_en, load_sm_en, wb DMEM, reg_we. STORE: ig S, ADD, dmem_en, store_inst. LUI: ig U, PASS_B, wb ALU. AUIPC: A=PC, ig U, ADD. JAL: A=PC, ig J, wb INC4, jump_inst. JALR: ig I, wb INC4, jump_inst. BRANCH: A=PC, ig B, bc_uns=f3[1], branch_inst.
- Branch/jump in RUN: stall_if=1, pc_we=0, latch funct3 and jump flag; -> RESOLVE.
- RESOLVE: taken = jump | (f3 000:eq, 001:!eq, 100/110:lt, 101/111:!lt). Taken: pc_sel=ALU, pc_we=1, clear_if=clear_id=1, bubble; -> FLUSH (load counter) or RUN if FLUSH_CYCLES=0. Not taken: normal RUN decode of inst_id.
- FLUSH: bubble, pc_sel=INC4, pc_we=1, inst_id ignored; counter decrements, -> RUN at 1.
- Illegal (inst_valid, opc[1:0]!=11 or unlisted opc5, or branch f3 010/011): EN_TRAP=1 -> TRAP: bubble, pc_we=0, stall_if=1, illegal_inst=1 until reset. EN_TRAP=0 -> bubble, INC4.

## Timing
- Reset (rst low, async): state START; pc_sel=START_ADDR, pc_we=1, all other outputs 0 (alu_op ADD, wb DMEM).
- Decode latency 1 cycle; branch redirect on second edge after branch sampled; redirect-to-RUN = 1+FLUSH_CYCLES edges.
- Reset mid-RESOLVE/FLUSH/TRAP: immediate return to reset values; counter cleared.
- inst_valid=0 in RESOLVE not-taken path: bubble.

## Structure
- Package ama_riscv_pkg: opcode OPC5_* constants, PC_SEL_*, ALU_A/B_SEL_*, IG_*, WB_SEL_*, ALU_OP_ADD/PASS_B, state enum.
- One sub-module: ama_riscv_branch_resolve (f3, flags, jump -> taken).

## Test plan
- Release rst: first edge pc_sel=2, pc_we=1; next edge RUN, bubble outputs until inst_valid.
- add x1,x2,x3 (0x003100B3) -> alu_op 0000, reg_we=1, wb_sel=1; sub (0x403100B3) -> alu_op 1000.
- beq taken (eq=1) -> RESOLVE edge: pc_sel=1, clear_if=clear_id=1; FLUSH_CYCLES=2 -> two bubbles then RUN.
- bltu not taken (lt=0) -> bc_uns=1, no clears, inst_id decoded on resolve edge.
- inst 0xFFFFFFFF, EN_TRAP=1 -> illegal_inst=1, pc_we=0 held; rst low clears.
- rst asserted during FLUSH -> outputs reset asynchronously, START on release.
